cacheline_adaptor: RTL

- Sits directly downstream of the cache datapath/control pair, between the cache's 256-bit physical-memory port and the 64-bit burst DRAM interface.
- Converts one cacheline read into a 4-beat burst read, assembling the beats into a line.
- Converts one cacheline writeback into a 4-beat burst write, slicing the line into beats.
- Reports completion to the cache with a single-cycle response.

---
 rtl/cacheline_adaptor.sv | 75 +++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges 256-bit cacheline read/writeback requests to 4-beat 64-bit DRAM bursts
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  localparam int n_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int cw = $clog2(n_beats);
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state, w_next;
  logic [cw-1:0]     r_cnt;
  logic [31:0]       r_addr;
  logic [s_line-1:0] r_wline;
  logic [s_line-1:0] r_line_o;
  logic              w_last;

  assign w_last    = r_cnt == cw'(n_beats - 1);
  assign line_o    = r_line_o;
  assign address_o = r_addr;
  assign read_o    = r_state == READ;
  assign write_o   = r_state == WRITE;
  assign resp_o    = r_state == DONE;
  assign burst_o   = (r_state == WRITE) ? r_wline[r_cnt*s_burst +: s_burst] : '0;

  // state register; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;

  // next state: read wins over write in IDLE, last beat ends the burst
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = read_i ? READ : write_i ? WRITE : IDLE;
      READ:    w_next = (resp_i && w_last) ? DONE : READ;
      WRITE:   w_next = (resp_i && w_last) ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end

  // datapath: latch request at launch, count beats, assemble read line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wline  <= '0;
      r_line_o <= '0;
    end else begin
      if (r_state == IDLE && (read_i || write_i)) begin
        r_cnt  <= '0;
        r_addr <= address_i & addr_mask;
        if (!read_i) r_wline <= line_i;
      end
      if ((r_state == READ || r_state == WRITE) && resp_i) r_cnt <= r_cnt + 1'b1;
      if (r_state == READ && resp_i) r_line_o[r_cnt*s_burst +: s_burst] <= burst_i;
    end
endmodule
